// File: rtl/rv_isa_pkg.sv
// Purpose: shared RV32I opcode constants, error codes, encoder state type and field bundle.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: OP_* opcodes, ERR_* codes, enc_state_t, instr_fields_t, imm_fits() range helper.
package rv_isa_pkg;

  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_RTYPE  = 7'h33;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_IMM_RANGE = 2'd1;
  localparam logic [1:0] ERR_BAD_OP    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_WRITE  = 2'd2
  } enc_state_t;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } instr_fields_t;

  // True when imm[31:msb] are all equal, i.e. the value is representable as a
  // signed (msb+1)-bit number.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] upper;
    upper = 32'($signed(imm) >>> msb);
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_writer_imm_pack_check.sv
// Purpose: pack a decoded field bundle into an RV32I word and range-check the immediate.
// Latency: purely combinational.
// Backpressure: none; output follows input every cycle.
// Ports: fields_i (field bundle), instr_o (packed word), err_code_o (ERR_NONE / ERR_IMM_RANGE / ERR_BAD_OP).
module imm_pack_check
  import rv_isa_pkg::*;
(
  input  instr_fields_t fields_i,
  output logic [31:0]   instr_o,
  output logic [1:0]    err_code_o
);

  logic [31:0] imm;
  assign imm = fields_i.imm;

  always_comb begin
    instr_o    = '0;
    err_code_o = ERR_NONE;
    case (fields_i.op)
      OP_ITYPE, OP_LOAD, OP_JALR: begin
        instr_o = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, fields_i.op};
        if (!imm_fits(imm, 11)) err_code_o = ERR_IMM_RANGE;
      end
      OP_STORE: begin
        instr_o = {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3, imm[4:0], fields_i.op};
        if (!imm_fits(imm, 11)) err_code_o = ERR_IMM_RANGE;
      end
      OP_BRANCH: begin
        instr_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                   imm[4:1], imm[11], fields_i.op};
        // Branch targets are halfword aligned; bit 0 has no slot in the word.
        if (!imm_fits(imm, 12) || imm[0]) err_code_o = ERR_IMM_RANGE;
      end
      OP_LUI: begin
        // Immediate arrives unshifted: the 20-bit upper value, sign-extended.
        instr_o = {imm[19:0], fields_i.rd, fields_i.op};
        if (!imm_fits(imm, 19)) err_code_o = ERR_IMM_RANGE;
      end
      OP_JAL: begin
        instr_o = {imm[20], imm[10:1], imm[11], imm[19:12], fields_i.rd, fields_i.op};
        if (!imm_fits(imm, 20) || imm[0]) err_code_o = ERR_IMM_RANGE;
      end
      OP_RTYPE: begin
        instr_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3,
                   fields_i.rd, fields_i.op};
      end
      default: err_code_o = ERR_BAD_OP;
    endcase
  end

endmodule

// File: rtl/instr_encoder_writer.sv
// Purpose: encode field bundles into RV32I words and write them sequentially into instruction memory.
// Latency: bundle accepted at edge N, we_o high in cycle N+2; one word every 3 cycles.
// Backpressure: ready_o only in IDLE and not full; deasserted while full_o until start_i.
// Ports: clk/reset (async active-low); start_i restart; valid_i/ready_o + *_i fields in;
//        instr_o/addr_o/we_o memory write port; full_o, err_o, err_code_o, word_count_o status.
module instr_encoder_writer
  import rv_isa_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [6:0]            op_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [31:0]           imm_i,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  we_o,
  output logic                  full_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  enc_state_t            state_q, state_d;
  instr_fields_t         fields_q;
  logic [31:0]           instr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  full_q;
  logic                  err_q;
  logic [1:0]            code_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  // Holds ready_o low while reset is asserted; set on the first edge after release.
  logic                  run_q;

  logic [31:0] pack_instr;
  logic [1:0]  pack_err;
  logic        accept;

  imm_pack_check u_pack (
    .fields_i   (fields_q),
    .instr_o    (pack_instr),
    .err_code_o (pack_err)
  );

  assign ready_o = run_q && (state_q == ST_IDLE) && !full_q && !start_i;
  assign accept  = valid_i && ready_o;
  // A restart in the WRITE cycle suppresses the strobe so the dropped word never lands.
  assign we_o    = (state_q == ST_WRITE) && !start_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ENCODE;
      ST_ENCODE: state_d = (pack_err == ERR_NONE) ? ST_WRITE : ST_IDLE;
      ST_WRITE:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (start_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      fields_q <= '0;
      instr_q  <= '0;
      addr_q   <= BASE_ADDR;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (start_i) begin
        addr_q <= BASE_ADDR;
        cnt_q  <= '0;
        full_q <= 1'b0;
        err_q  <= 1'b0;
        code_q <= ERR_NONE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              fields_q <= '{op: op_i, funct3: funct3_i, funct7: funct7_i, rd: rd_i,
                            rs1: rs1_i, rs2: rs2_i, imm: imm_i};
            end
          end
          ST_ENCODE: begin
            if (pack_err == ERR_NONE) begin
              instr_q <= pack_instr;
            end else begin
              err_q  <= 1'b1;
              code_q <= pack_err;
            end
          end
          ST_WRITE: begin
            cnt_q <= cnt_q + (ADDR_WIDTH+1)'(1);
            // Top address is terminal: park there and refuse further words.
            if (addr_q == LAST_ADDR) full_q <= 1'b1;
            else                     addr_q <= addr_q + ADDR_WIDTH'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign instr_o      = instr_q;
  assign addr_o       = addr_q;
  assign full_o       = full_q;
  assign err_o        = err_q;
  assign err_code_o   = code_q;
  assign word_count_o = cnt_q;

endmodule

// File: tb/tb_instr_encoder_writer.sv
module tb_instr_encoder_writer;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic          valid_i;
  logic          ready_o;
  logic [6:0]    op_i;
  logic [2:0]    funct3_i;
  logic [6:0]    funct7_i;
  logic [4:0]    rd_i;
  logic [4:0]    rs1_i;
  logic [4:0]    rs2_i;
  logic [31:0]   imm_i;
  logic [31:0]   instr_o;
  logic [AW-1:0] addr_o;
  logic          we_o;
  logic          full_o;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic [AW:0]   word_count_o;

  int checks = 0;
  int errors = 0;

  instr_encoder_writer #(.ADDR_WIDTH(AW), .BASE_ADDR('0)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .op_i         (op_i),
    .funct3_i     (funct3_i),
    .funct7_i     (funct7_i),
    .rd_i         (rd_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .imm_i        (imm_i),
    .instr_o      (instr_o),
    .addr_o       (addr_o),
    .we_o         (we_o),
    .full_o       (full_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o),
    .word_count_o (word_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    op_i = op; funct3_i = f3; funct7_i = f7; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
  endtask

  // Offers one bundle in IDLE and checks the write strobe lands exactly two cycles after accept.
  task automatic send_word(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic exp_we,
                           input logic [31:0] exp_instr, input logic [31:0] exp_addr,
                           input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    drive(op, f3, f7, rd, rs1, rs2, imm);
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    chk({tag, "_we_n1"}, 32'(we_o), 32'd0);
    @(negedge clk);
    chk({tag, "_we_n2"}, 32'(we_o), 32'(exp_we));
    if (exp_we) begin
      chk({tag, "_instr"}, instr_o, exp_instr);
      chk({tag, "_addr"}, 32'(addr_o), exp_addr);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start_i = 1'b0; valid_i = 1'b0;
    drive('0, '0, '0, '0, '0, '0, '0);

    // Reset values while reset is held
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_addr", 32'(addr_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_code", 32'(err_code_o), 32'd0);
    chk("rst_cnt", 32'(word_count_o), 32'd0);
    reset = 1'b1;

    // addi x1, x0, -1
    send_word(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0093, 32'd0, "addi");
    @(negedge clk);
    chk("addi_cnt", 32'(word_count_o), 32'd1);
    chk("addi_addr_next", 32'(addr_o), 32'd1);

    // branch then store back to back from a fresh start
    pulse_start();
    send_word(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020_8463, 32'd0, "beq");
    send_word(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd12, 1'b1, 32'h0020_A623, 32'd1, "sw");
    @(negedge clk);
    chk("bs_cnt", 32'(word_count_o), 32'd2);

    // lui / jal
    pulse_start();
    send_word(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h0001_2345, 1'b1, 32'h1234_52B7, 32'd0, "lui");
    send_word(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h0010_00EF, 32'd1, "jal");

    // Error path: out-of-range imm, misaligned branch, unknown opcode
    pulse_start();
    send_word(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'd0, 32'd0, "addi_big");
    chk("e1_err", 32'(err_o), 32'd1);
    chk("e1_code", 32'(err_code_o), 32'd1);
    chk("e1_addr", 32'(addr_o), 32'd0);
    chk("e1_cnt", 32'(word_count_o), 32'd0);
    send_word(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'd0, 32'd0, "beq_odd");
    chk("e2_code", 32'(err_code_o), 32'd1);
    send_word(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, "badop");
    chk("e3_code", 32'(err_code_o), 32'd2);
    chk("e3_addr", 32'(addr_o), 32'd0);
    send_word(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, 32'd0, "addi_ok");
    chk("e4_err_sticky", 32'(err_o), 32'd1);
    chk("e4_code_kept", 32'(err_code_o), 32'd2);

    // Fill the remaining three addresses of the 4-word memory
    send_word(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 1'b1, 32'h0020_81B3, 32'd1, "add");
    send_word(7'h03, 3'd2, 7'd0, 5'd4, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b1, 32'hFFC1_2203, 32'd2, "lw");
    send_word(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b1, 32'h8000_0093, 32'd3, "addi_min");
    @(negedge clk);
    chk("full_flag", 32'(full_o), 32'd1);
    chk("full_ready", 32'(ready_o), 32'd0);
    chk("full_addr", 32'(addr_o), 32'd3);
    chk("full_cnt", 32'(word_count_o), 32'd4);

    // Fifth bundle while full must be ignored
    drive(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1);
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_no_we", 32'(we_o), 32'd0);
    end
    valid_i = 1'b0;
    chk("full_cnt_hold", 32'(word_count_o), 32'd4);

    // Restart clears everything
    pulse_start();
    @(negedge clk);
    chk("st_addr", 32'(addr_o), 32'd0);
    chk("st_full", 32'(full_o), 32'd0);
    chk("st_ready", 32'(ready_o), 32'd1);
    chk("st_err", 32'(err_o), 32'd0);
    chk("st_code", 32'(err_code_o), 32'd0);
    chk("st_cnt", 32'(word_count_o), 32'd0);

    // start_i while the word is in ENCODE drops it
    drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_we", 32'(we_o), 32'd0);
    end
    chk("abort_cnt", 32'(word_count_o), 32'd0);
    chk("abort_addr", 32'(addr_o), 32'd0);

    // Reset asserted in the WRITE cycle
    @(negedge clk);
    drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9);
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rw_we", 32'(we_o), 32'd0);
    chk("rw_instr", instr_o, 32'd0);
    chk("rw_addr", 32'(addr_o), 32'd0);
    chk("rw_ready", 32'(ready_o), 32'd0);
    chk("rw_cnt", 32'(word_count_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rw_no_we", 32'(we_o), 32'd0);
    end
    chk("rw_ready_back", 32'(ready_o), 32'd1);
    chk("rw_cnt_after", 32'(word_count_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_writer.md
Name: instr_encoder_writer

Overview:
- Inverse of the immediate decode path: takes decoded instruction fields (opcode, registers, functs, signed immediate) and packs them into a 32-bit RV32I instruction word.
- Range-checks the immediate for the target format and writes accepted words sequentially into program/instruction memory.
- Used by the boot/test loader to fill instruction memory before the pipeline is released from reset.
- Round-trip contract: a packed word fed to the immediate decoder returns the same imm_i.

Parameters:
ADDR_WIDTH, 8, word-address width of the instruction memory write port
BASE_ADDR, 0, first word address after reset or start_i

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start_i  input  1  synchronous restart: address to BASE_ADDR, clears full_o/err state, aborts any in-flight word
valid_i  input  1  field bundle valid
ready_o  output  1  encoder can accept a bundle
op_i  input  7  opcode
funct3_i  input  3  funct3 (ignored for U/J)
funct7_i  input  7  funct7 (R only)
rd_i  input  5  destination register
rs1_i  input  5  source register 1
rs2_i  input  5  source register 2
imm_i  input  32  signed immediate; U format carries the unshifted 20-bit value, sign-extended
instr_o  output  32  packed instruction (memory write data)
addr_o  output  ADDR_WIDTH  memory write word address
we_o  output  1  memory write strobe, one cycle per word
full_o  output  1  last address written; no further accepts
err_o  output  1  sticky error flag
err_code_o  output  2  0 none, 1 immediate out of range, 2 unsupported opcode (last error)
word_count_o  output  ADDR_WIDTH+1  words written since start

Behaviour:
- Reset (async, reset==0): state IDLE, ready_o=0 during reset then 1, instr_o=0, addr_o=BASE_ADDR, we_o=0, full_o=0, err_o=0, err_code_o=0, word_count_o=0.
- FSM IDLE -> ENCODE -> WRITE -> IDLE.
- IDLE: ready_o = !full_o. On valid_i && ready_o, capture all fields into registers and go to ENCODE. ready_o=0 in every other state.
- ENCODE: pack and check in one cycle, register instr_o.
  - On pass: go to WRITE.
  - On failure: set err_o, set err_code_o, go to IDLE with no write and addr unchanged.
- WRITE: we_o=1 for exactly this cycle with instr_o and addr_o stable. Next edge: addr_o+1, word_count_o+1, return to IDLE.
- Latency: accept at edge N, we_o high in cycle N+2. Throughput is one word per 3 cycles.
- Packing by opcode:
  - I (0x13, 0x03, 0x67): {imm[11:0], rs1, f3, rd, op}. Legal if imm[31:11] all equal.
  - S (0x23): {imm[11:5], rs2, rs1, f3, imm[4:0], op}. Legal if imm[31:11] all equal.
  - B (0x63): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}. Legal if imm[31:12] all equal and imm[0]==0.
  - U (0x37): {imm[19:0], rd, op}. Legal if imm[31:19] all equal.
  - J (0x6F): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}. Legal if imm[31:20] all equal and imm[0]==0.
  - R (0x33): {f7, rs2, rs1, f3, rd, op}. imm_i ignored.
  - Any other opcode: error code 2.
- Full / wrap-around: the write to address 2^ADDR_WIDTH-1 sets full_o; addr_o stays there and never wraps silently. While full_o, ready_o=0 until start_i.
- start_i has priority over all states:
  - Next state IDLE, we_o=0, pending word dropped.
  - addr_o=BASE_ADDR, word_count_o=0, full_o=0, err_o=0, err_code_o=0.
  - valid_i in the same cycle as start_i is not accepted.
- Reset mid-operation: immediate return to reset values; no partial write is ever emitted.
- err_o is sticky across later good words; err_code_o reflects the most recent error.

Decomposition:
- Shared package (rv_isa_pkg): opcode constants OP_ITYPE 0x13, OP_LOAD 0x03, OP_JALR 0x67, OP_STORE 0x23, OP_BRANCH 0x63, OP_LUI 0x37, OP_JAL 0x6F, OP_RTYPE 0x33; error-code constants.
- Sub-module imm_pack_check: purely combinational packing plus range check, reused by the verification scoreboard. FSM, address counter and status stay in the top.

Test Plan:
- addi: op 0x13, rd 1, rs1 0, f3 0, imm -1 -> instr_o 0xFFF00093, we_o at N+2, addr 0.
- Branch then store back-to-back: op 0x63 (rs1 1, rs2 2, imm 8) and op 0x23 (rs1 1, rs2 2, f3 2, imm 12) -> 0x00208463 at addr 0, 0x0020A623 at addr 1, word_count 2.
- lui / jal: op 0x37 (rd 5, imm 0x12345) -> 0x123452B7; op 0x6F (rd 1, imm 2048) -> 0x001000EF.
- Errors: addi imm 2048 -> no we_o, err_o=1, code 1, addr unchanged. Then op 0x7F -> code 2. Then a valid addi writes normally and err_o stays 1.
- Full: ADDR_WIDTH=2 -> 4 writes -> full_o=1, ready_o=0, fifth valid_i ignored. start_i -> addr 0, full_o=0, ready_o=1.
- Abort: start_i asserted in ENCODE, and separately reset pulsed in WRITE -> no we_o pulse, all outputs at reset values.
